// File: rtl/slice_unpacker_pkg.sv
// Shared types and helpers for the slice unpacker (state encoding and ratio helper).
package slice_unpacker_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic int slice_ratio(input int data_w, input int slice_w);
      return data_w / slice_w;
   endfunction

endpackage

// File: rtl/slice_unpacker.sv
// Width-down converter: one DATA_W-bit word leaves as DATA_W/SLICE_W slices, MSB slice first,
// with valid/ready handshakes on both sides and no bubble between back-to-back words.
module slice_unpacker
   import slice_unpacker_pkg::*;
#(
   parameter int DATA_W  = 4,
   parameter int SLICE_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SLICE_W-1:0] out_data,
   output logic               out_last
);

   localparam int RATIO = slice_ratio(DATA_W, SLICE_W);
   localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;

   if (((DATA_W % SLICE_W) != 0) || (RATIO < 2)) begin : g_bad_params
      $error("slice_unpacker: DATA_W must be a multiple of SLICE_W with a ratio of at least 2");
   end

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  word_q, word_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               is_last;

   assign is_last   = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(RATIO - 1));
   assign out_valid = (state_q == ST_SHIFT);
   assign out_last  = is_last;
   assign out_data  = out_valid ? word_q[DATA_W-1 -: SLICE_W] : '0;
   assign in_ready  = (state_q == ST_IDLE) || (is_last && out_ready);

   // Reset drops any word in flight so no partial slices appear after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
      end
   end

   // On the last-slice handshake a waiting word is loaded directly to keep throughput at one slice per cycle.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_SHIFT;
               word_d  = in_data;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (out_ready) begin
               if (!is_last) begin
                  word_d = word_q << SLICE_W;
                  cnt_d  = cnt_q + CNT_W'(1);
               end else if (in_valid) begin
                  word_d = in_data;
                  cnt_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_slice_unpacker.sv
// Directed bench for slice_unpacker: a 4->2 instance for the handshake cases and an 8->2 instance.
module tb_slice_unpacker;

   logic       clk;
   logic       rst_n;

   logic       in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
   logic [3:0] in_data4;
   logic [1:0] out_data4;

   logic       in_valid8, in_ready8, out_valid8, out_ready8, out_last8;
   logic [7:0] in_data8;
   logic [1:0] out_data8;

   int errors = 0;
   int checks = 0;

   slice_unpacker #(.DATA_W(4), .SLICE_W(2)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .in_data   (in_data4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_data  (out_data4),
      .out_last  (out_last4)
   );

   slice_unpacker #(.DATA_W(8), .SLICE_W(2)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .in_data   (in_data8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .out_data  (out_data8),
      .out_last  (out_last8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic iv, input logic [3:0] id, input logic ordy);
      in_valid4  = iv;
      in_data4   = id;
      out_ready4 = ordy;
      #1;
   endtask

   initial begin
      logic [1:0] exp8 [4];
      exp8[0] = 2'b11; exp8[1] = 2'b10; exp8[2] = 2'b01; exp8[3] = 2'b00;

      rst_n = 1'b0;
      in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
      in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;

      // 1 reset
      #2;
      checkOutput("rst_out_valid", out_valid4, 0);
      checkOutput("rst_out_data", out_data4, 0);
      checkOutput("rst_out_last", out_last4, 0);
      #10 rst_n = 1'b1;
      tick;
      checkOutput("rst_in_ready", in_ready4, 1);

      // 2 single word
      applyStimulus(1'b1, 4'b1101, 1'b1);
      tick;
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("single_v0", out_valid4, 1);
      checkOutput("single_d0", out_data4, 2'b11);
      checkOutput("single_l0", out_last4, 0);
      tick;
      checkOutput("single_d1", out_data4, 2'b01);
      checkOutput("single_l1", out_last4, 1);
      tick;
      checkOutput("single_idle_v", out_valid4, 0);
      checkOutput("single_idle_rdy", in_ready4, 1);

      // 3 back-to-back
      applyStimulus(1'b1, 4'hA, 1'b1);
      tick;
      applyStimulus(1'b1, 4'h5, 1'b1);
      checkOutput("b2b_d0", out_data4, 2'b10);
      checkOutput("b2b_l0", out_last4, 0);
      checkOutput("b2b_rdy0", in_ready4, 0);
      tick;
      checkOutput("b2b_d1", out_data4, 2'b10);
      checkOutput("b2b_l1", out_last4, 1);
      checkOutput("b2b_rdy1", in_ready4, 1);
      tick;
      applyStimulus(1'b0, 4'h0, 1'b1);
      checkOutput("b2b_v2", out_valid4, 1);
      checkOutput("b2b_d2", out_data4, 2'b01);
      checkOutput("b2b_l2", out_last4, 0);
      tick;
      checkOutput("b2b_d3", out_data4, 2'b01);
      checkOutput("b2b_l3", out_last4, 1);
      tick;
      checkOutput("b2b_idle", out_valid4, 0);

      // 4 backpressure
      applyStimulus(1'b1, 4'b0110, 1'b0);
      tick;
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkOutput("bp_d0", out_data4, 2'b01);
      for (int i = 0; i < 3; i++) begin
         tick;
         checkOutput("bp_hold_d", out_data4, 2'b01);
         checkOutput("bp_hold_l", out_last4, 0);
         checkOutput("bp_hold_rdy", in_ready4, 0);
      end
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput("bp_rel_d0", out_data4, 2'b01);
      tick;
      checkOutput("bp_rel_d1", out_data4, 2'b10);
      checkOutput("bp_rel_l1", out_last4, 1);
      tick;
      checkOutput("bp_idle", out_valid4, 0);

      // 5 mid-operation reset
      applyStimulus(1'b1, 4'hF, 1'b1);
      tick;
      applyStimulus(1'b0, 4'h0, 1'b1);
      checkOutput("mrst_d0", out_data4, 2'b11);
      rst_n = 1'b0;
      #1;
      checkOutput("mrst_async_v", out_valid4, 0);
      checkOutput("mrst_async_d", out_data4, 0);
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         checkOutput("mrst_no_slice", out_valid4, 0);
      end

      // 6 wide instance
      in_valid8 = 1'b1; in_data8 = 8'hE4; out_ready8 = 1'b1;
      tick;
      in_valid8 = 1'b0; in_data8 = 8'h00;
      #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("w8_v", out_valid8, 1);
         checkOutput("w8_d", out_data8, exp8[i]);
         checkOutput("w8_l", out_last8, (i == 3) ? 1'b1 : 1'b0);
         tick;
      end
      checkOutput("w8_idle", out_valid8, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
